// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Width needed to hold the iteration count N itself.
    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the result only when it stays non-negative.
module divider_step #(
    parameter int N = 16
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_nx,
    output logic [N-1:0] quo_nx
);

    logic [N:0] shifted;
    logic [N:0] trial;
    logic       unused_rem_msb;

    // The partial remainder never reaches the divisor, so its MSB is always
    // clear on entry and only the low N bits are shifted up.
    assign unused_rem_msb = rem[N];

    // Trial subtraction and commit/restore decision.
    always_comb begin
        shifted = {rem[N-1:0], quo[N-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[N]) begin
            rem_nx = trial;
            quo_nx = {quo[N-2:0], 1'b1};
        end else begin
            rem_nx = shifted;
            quo_nx = {quo[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_sh.sv
// Multi-cycle signed/unsigned restoring divider with start/ready handshake,
// divide-by-zero and signed-overflow fast paths, and a one-cycle done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready=1, waiting for start; results from last op held
//   CALC  | one restoring step per clock, counter runs N down to 1
//   FIX   | apply signs or fast-path values, load outputs, pulse done
module divider_sh
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic [N-1:0] Q,
    output logic [N-1:0] A,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = calc_cw(N);
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [N:0]     rem;
    logic [N-1:0]   quo;
    logic [N-1:0]   dvs;
    logic           neg_q;
    logic           neg_r;
    logic           fz;
    logic           fo;

    logic [N:0]     rem_nx;
    logic [N-1:0]   quo_nx;
    logic           in_dz;
    logic           in_ov;
    logic [N-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic [N-1:0]   q_res;
    logic [N-1:0]   a_res;

    assign in_dz   = (divisor == '0);
    assign in_ov   = is_signed && (dividend == SMIN) && (divisor == '1);
    assign dvd_mag = (is_signed && dividend[N-1]) ? -dividend : dividend;
    assign dvs_mag = (is_signed && divisor[N-1])  ? -divisor  : divisor;

    divider_step #(.N(N)) u_step (
        .rem    (rem),
        .quo    (quo),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; special operands skip the iteration loop.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (in_dz || in_ov) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake output.
    always_comb begin
        ready = (state == IDLE);
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            fz    <= 1'b0;
            fo    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fz    <= in_dz;
                        fo    <= in_ov;
                        neg_q <= is_signed && (dividend[N-1] ^ divisor[N-1]);
                        neg_r <= is_signed && dividend[N-1];
                        dvs   <= dvs_mag;
                        rem   <= '0;
                        // Divide-by-zero reports the raw dividend, so keep it
                        // unmodified in the quotient register.
                        quo   <= in_dz ? dividend : dvd_mag;
                        cnt   <= (in_dz || in_ov) ? '0 : CW'(N);
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Final result selection with sign correction.
    always_comb begin
        q_res = neg_q ? -quo : quo;
        a_res = neg_r ? -rem[N-1:0] : rem[N-1:0];
        if (fz) begin
            q_res = '1;
            a_res = quo;
        end else if (fo) begin
            q_res = SMIN;
            a_res = '0;
        end
    end

    // Result and flag registers, loaded only on completion and held after.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Q           <= '0;
            A           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX) begin
                done        <= 1'b1;
                Q           <= q_res;
                A           <= a_res;
                div_by_zero <= fz;
                overflow    <= fo;
            end
        end
    end

endmodule

// File: tb/tb_divider_sh.sv
// Self-checking bench for divider_sh (N=16): directed cases, back-to-back,
// ignored start while busy, reset abort, and randomized operations.
module tb_divider_sh;

    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         ready;
    logic [N-1:0] Q;
    logic [N-1:0] A;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    divider_sh #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .Q           (Q),
        .A           (A),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // Reference: integer division truncating toward zero, remainder follows
    // the dividend's sign, plus the two special-operand rules.
    task automatic model(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov);
        int sa;
        int sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 16'd0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else if (sgn && a == 16'h8000 && b == 16'hFFFF) begin
            q  = 16'h8000;
            r  = 16'h0000;
            ov = 1'b1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 16'(int'(a) % int'(b));
        end
    endtask

    // Presents start for one cycle, scrambles the operands afterwards, and
    // returns once done is seen (caller is then sitting in the done cycle).
    task automatic run_op(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dz, output logic ov,
                          output int lat, output logic rdy);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        lat       = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) begin
                start     = 1'b0;
                dividend  = 16'($urandom);
                divisor   = 16'($urandom);
                is_signed = 1'($urandom);
            end
        end while (!done && lat < 40);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles for %h/%h", lat, a, b);
        end
        q   = Q;
        r   = A;
        dz  = div_by_zero;
        ov  = overflow;
        rdy = ready;
    endtask

    task automatic test_reset();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b done=%b, required ready=1 done=0", ready, done);
        end
        checks++;
        if (Q !== 16'h0 || A !== 16'h0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: Q=%h A=%h dz=%b ov=%b, required all zero",
                     Q, A, div_by_zero, overflow);
        end
    endtask

    task automatic test_directed();
        vec_t        v[9];
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        logic        rdy;
        int          lat;
        v[0] = '{1'b0, 16'd23,    16'd5,    16'd4,    16'd3,    1'b0, 1'b0, 18};
        v[1] = '{1'b0, 16'd12345, 16'd678,  16'd18,   16'd141,  1'b0, 1'b0, 18};
        v[2] = '{1'b1, 16'hFFE9,  16'd5,    16'hFFFC, 16'hFFFD, 1'b0, 1'b0, 18};
        v[3] = '{1'b1, 16'd23,    16'hFFFB, 16'hFFFC, 16'd3,    1'b0, 1'b0, 18};
        v[4] = '{1'b1, 16'hFFE9,  16'hFFFB, 16'd4,    16'hFFFD, 1'b0, 1'b0, 18};
        v[5] = '{1'b0, 16'd100,   16'd0,    16'hFFFF, 16'd100,  1'b1, 1'b0, 2};
        v[6] = '{1'b1, 16'h8000,  16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 2};
        v[7] = '{1'b0, 16'h8000,  16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 18};
        v[8] = '{1'b1, 16'hFFE9,  16'd0,    16'hFFFF, 16'hFFE9, 1'b1, 1'b0, 2};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].sgn, v[i].a, v[i].b, q, r, dz, ov, lat, rdy);
            checks++;
            if (q !== v[i].q || r !== v[i].r) begin
                errors++;
                $display("FAIL directed_%0d result: Q=%h A=%h, required Q=%h A=%h",
                         i, q, r, v[i].q, v[i].r);
            end
            checks++;
            if (dz !== v[i].dz || ov !== v[i].ov) begin
                errors++;
                $display("FAIL directed_%0d flags: dz=%b ov=%b, required dz=%b ov=%b",
                         i, dz, ov, v[i].dz, v[i].ov);
            end
            checks++;
            if (lat !== v[i].lat || rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d timing: latency=%0d ready=%b, required %0d and 1",
                         i, lat, rdy, v[i].lat);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        logic        rdy;
        int          lat;
        run_op(1'b0, 16'd12345, 16'd678, q, r, dz, ov, lat, rdy);
        checks++;
        if (q !== 16'd18 || r !== 16'd141 || lat !== 18) begin
            errors++;
            $display("FAIL b2b_first: Q=%0d A=%0d lat=%0d, required Q=18 A=141 lat=18", q, r, lat);
        end
        run_op(1'b0, 16'hFFFF, 16'd1, q, r, dz, ov, lat, rdy);
        checks++;
        if (q !== 16'hFFFF || r !== 16'h0 || dz !== 1'b0 || lat !== 18) begin
            errors++;
            $display("FAIL b2b_second: Q=%h A=%h dz=%b lat=%0d, required Q=ffff A=0 dz=0 lat=18",
                     q, r, dz, lat);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_busy_start();
        int lat;
        int extra;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'd23;
        divisor   = 16'd5;
        lat       = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            start = (lat == 3);
            if (lat == 3) begin
                dividend = 16'd7;
                divisor  = 16'd1;
            end
        end while (!done && lat < 40);
        checks++;
        if (done !== 1'b1 || Q !== 16'd4 || A !== 16'd3 || lat !== 18) begin
            errors++;
            $display("FAIL busy_start_result: done=%b Q=%0d A=%0d lat=%0d, required 1 4 3 18",
                     done, Q, A, lat);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || ready !== 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || Q !== 16'd4) begin
            errors++;
            $display("FAIL busy_start_queued: %0d busy/done cycles after result, Q=%0d, required 0 and 4",
                     extra, Q);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 16'd23;
        divisor   = 16'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (ready !== 1'b0 || Q !== 16'd4) begin
            errors++;
            $display("FAIL abort_precond: ready=%b Q=%0d, required busy with held Q=4", ready, Q);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Q !== 16'h0 || A !== 16'h0 || ready !== 1'b1 || done !== 1'b0 ||
            div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: Q=%h A=%h ready=%b done=%b dz=%b ov=%b, required 0 0 1 0 0 0",
                     Q, A, ready, done, div_by_zero, overflow);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || ready !== 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || Q !== 16'h0) begin
            errors++;
            $display("FAIL abort_no_done: %0d busy/done cycles after release, Q=%h, required 0 and 0",
                     dones, Q);
        end
    endtask

    task automatic test_random();
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic [15:0] eq;
        logic [15:0] er;
        logic        dz;
        logic        ov;
        logic        edz;
        logic        eov;
        logic        rdy;
        int          lat;
        int          elat;
        int          idle;
        for (int i = 0; i < 150; i++) begin
            sgn = 1'($urandom);
            a   = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'd0;
                1:       begin a = 16'h8000; b = 16'hFFFF; end
                2:       b = 16'($urandom_range(1, 15));
                3:       b = 16'hFFFF - 16'($urandom_range(0, 7));
                default: b = 16'($urandom);
            endcase
            model(sgn, a, b, eq, er, edz, eov);
            elat = (edz || eov) ? 2 : 18;
            run_op(sgn, a, b, q, r, dz, ov, lat, rdy);
            checks++;
            if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== elat) begin
                errors++;
                $display("FAIL random_%0d s=%b %h/%h: Q=%h A=%h dz=%b ov=%b lat=%0d, required %h %h %b %b %0d",
                         i, sgn, a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
            end
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(posedge clock);
                #1;
            end
            if (idle > 0) begin
                checks++;
                if (done !== 1'b0 || Q !== eq || A !== er) begin
                    errors++;
                    $display("FAIL random_%0d hold: done=%b Q=%h A=%h, required 0 %h %h",
                             i, done, Q, A, eq, er);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_start();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
